// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: bus commands, arbiter FSM encoding and the
// fixed I/O register addresses decoded outside the arbiter.
package mem_bus_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD  = 2'b10;

  localparam logic [8:0] LED = 9'h100;
  localparam logic [8:0] SW  = 9'h140;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_t;

  // 2'b11 and MNONE are not transactions and must never win arbitration.
  function automatic logic is_active_cmd(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone eligible port wins outright, a tie goes to
// the port that was not granted last.
module rr_pick2 (
  input  logic [1:0] elig,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |elig;
    pick  = 1'b0;
    case (elig)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-outstanding shared memory bus.
// Handshake: reqN/cmdN/addrN/wdataN are held by the master until ackN, a one-cycle pulse; the bus is driven for exactly one ACCESS cycle.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [1:0]    cmd0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] w_data,
  input  logic [DW-1:0] r_data,
  output logic          busy,
  output state_t        dbg_state
);

  state_t     state, next_state;
  logic [1:0] elig;
  logic       pick_valid, pick;
  logic       last_gnt;
  logic       gnt;
  logic [1:0] cmd_q;

  assign elig = {req1 & is_active_cmd(cmd1), req0 & is_active_cmd(cmd0)};

  rr_pick2 u_pick (
    .elig  (elig),
    .last  (last_gnt),
    .valid (pick_valid),
    .pick  (pick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (pick_valid) next_state = S_ACCESS;
      S_ACCESS: next_state = S_RESP;
      S_RESP:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Bus command and acks decode straight from state so an asynchronous reset
  // drops them immediately, aborting an ACCESS before it reaches the RAM.
  always_comb begin
    mem_cmd = MNONE;
    ack0    = 1'b0;
    ack1    = 1'b0;
    busy    = (state != S_IDLE);
    case (state)
      S_ACCESS: mem_cmd = cmd_q;
      S_RESP: begin
        ack0 = ~gnt;
        ack1 = gnt;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

  // Granted transaction is latched at the grant edge; requester inputs are
  // ignored from then on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      cmd_q    <= MNONE;
      mem_addr <= '0;
      w_data   <= '0;
    end else if (state == S_IDLE && pick_valid) begin
      last_gnt <= pick;
      gnt      <= pick;
      cmd_q    <= pick ? cmd1 : cmd0;
      mem_addr <= pick ? addr1 : addr0;
      w_data   <= pick ? wdata1 : wdata0;
    end
  end

  // Read data arrives in the RESP cycle and is captured on the edge leaving it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == S_RESP && cmd_q == MREAD) begin
      if (gnt) rdata1 <= r_data;
      else     rdata0 <= r_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural RAM on the bus, a bus/ack
// scoreboard fed by the stimulus, and rdata checks after each transaction.
module tb_mem_arbiter;
  import mem_bus_pkg::*;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  cmd0, cmd1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] w_data;
  logic [15:0] r_data;
  logic        busy;
  state_t      dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // {port, cmd, addr, wdata}
  logic [27:0] exp_q[$];
  bit          ack_due = 0;
  bit          exp_port = 0;

  logic [15:0] ram [0:511];
  bit   [511:0] written = '0;

  mem_arbiter #(.AW(9), .DW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .cmd0      (cmd0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .rdata0    (rdata0),
    .req1      (req1),
    .cmd1      (cmd1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata1    (rdata1),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .w_data    (w_data),
    .r_data    (r_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: unwritten words read back as 16'h1000 + address.
  always @(posedge clk) begin
    if (mem_cmd == MWRITE) begin
      ram[mem_addr]     <= w_data;
      written[mem_addr] <= 1'b1;
    end
    r_data <= written[mem_addr] ? ram[mem_addr] : (16'h1000 + {7'b0, mem_addr});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [27:0] e;
    if (!reset) begin
      ack_due = 0;
    end else begin
      if (ack_due) begin
        check("ack0_pulse", 32'(ack0), 32'(exp_port == 1'b0));
        check("ack1_pulse", 32'(ack1), 32'(exp_port == 1'b1));
        ack_due = 0;
      end else begin
        check("spurious_ack", 32'({ack1, ack0}), 32'd0);
      end
      if (mem_cmd != MNONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bus", 32'(mem_cmd), 32'(MNONE));
        end else begin
          e = exp_q.pop_front();
          check("bus_cmd",  32'(mem_cmd),  32'(e[26:25]));
          check("bus_addr", 32'(mem_addr), 32'(e[24:16]));
          check("bus_data", 32'(w_data),   32'(e[15:0]));
          exp_port = e[27];
          ack_due  = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; returns one negedge after the ack (IDLE cycle).
  task automatic run_txn(input bit port, input logic [1:0] cmd,
                         input logic [8:0] addr, input logic [15:0] wdata);
    int waited = 0;
    bit got = 0;
    if (port) begin req1 = 1; cmd1 = cmd; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1; cmd0 = cmd; addr0 = addr; wdata0 = wdata; end
    exp_q.push_back({port, cmd, addr, wdata});
    while (!got && waited < 8) begin
      @(negedge clk);
      waited++;
      if (waited == 1) begin
        check("busy_access", 32'(busy), 32'd1);
        // Scramble the granted master's inputs; the bus must use latched values.
        if (port) begin addr1 = 9'($urandom_range(0, 511)); wdata1 = 16'($urandom); end
        else      begin addr0 = 9'($urandom_range(0, 511)); wdata0 = 16'($urandom); end
      end
      got = port ? ack1 : ack0;
    end
    check("ack_seen", 32'(got), 32'd1);
    check("ack_latency", 32'(waited), 32'd2);
    if (port) begin req1 = 0; cmd1 = MNONE; end
    else      begin req0 = 0; cmd0 = MNONE; end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acks;
    int cyc;
    reset = 1;
    req0 = 0; cmd0 = MNONE; addr0 = '0; wdata0 = '0;
    req1 = 0; cmd1 = MNONE; addr1 = '0; wdata1 = '0;

    // Asynchronous reset, checked before any clock edge.
    #1 reset = 0;
    #2;
    check("rst_mem_cmd", 32'(mem_cmd), 32'(MNONE));
    check("rst_acks",    32'({ack1, ack0}), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_state",   32'(dbg_state), 32'(S_IDLE));
    check("rst_addr",    32'(mem_addr), 32'd0);
    check("rst_wdata",   32'(w_data), 32'd0);
    check("rst_rdata0",  32'(rdata0), 32'd0);
    check("rst_rdata1",  32'(rdata1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1;

    // Read then write on port 0: the write must leave rdata0 alone.
    run_txn(0, MREAD, 9'h005, 16'h0000);
    check("p0_read_init", 32'(rdata0), 32'h1005);
    run_txn(0, MWRITE, 9'h005, 16'hBEEF);
    check("p0_write_keeps_rdata", 32'(rdata0), 32'h1005);

    // Port 1 reads back the word port 0 wrote.
    run_txn(1, MREAD, 9'h005, 16'h0000);
    check("p1_read_beef", 32'(rdata1), 32'hBEEF);
    check("p1_read_rdata0_same", 32'(rdata0), 32'h1005);

    // Write to the LED register address.
    run_txn(0, MWRITE, LED, 16'h00A5);
    check("led_write_rdata0", 32'(rdata0), 32'h1005);

    // Requests with non-transaction commands are ignored.
    req0 = 1; cmd0 = MNONE; addr0 = 9'h033; wdata0 = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("ign_mnone_cmd",  32'(mem_cmd), 32'(MNONE));
      check("ign_mnone_busy", 32'(busy), 32'd0);
    end
    cmd0 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ign_11_busy", 32'(busy), 32'd0);
    end
    req0 = 0; cmd0 = MNONE;

    // Round-robin after reset: both held, order must be 0,1,0,1.
    pulse_reset();
    req0 = 1; cmd0 = MWRITE; addr0 = 9'h020; wdata0 = 16'hA0A0;
    req1 = 1; cmd1 = MREAD;  addr1 = 9'h021; wdata1 = 16'h5555;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, MWRITE, 9'h020, 16'hA0A0});
      exp_q.push_back({1'b1, MREAD,  9'h021, 16'h5555});
    end
    acks = 0;
    cyc  = 0;
    while (acks < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) acks++;
      if (acks == 4) begin
        req0 = 0; cmd0 = MNONE;
        req1 = 0; cmd1 = MNONE;
      end
    end
    check("rr_acks",   32'(acks), 32'd4);
    check("rr_cycles", 32'(cyc), 32'd11);
    @(negedge clk);
    check("rr_rdata1", 32'(rdata1), 32'h1021);
    check("rr_rdata0", 32'(rdata0), 32'd0);
    run_txn(1, MREAD, 9'h020, 16'h0000);
    check("rr_readback", 32'(rdata1), 32'hA0A0);

    // Reset during ACCESS of a write aborts it.
    run_txn(0, MWRITE, 9'h007, 16'h1111);
    req0 = 1; cmd0 = MWRITE; addr0 = 9'h007; wdata0 = 16'h2222;
    @(posedge clk);
    #2;
    check("abort_pre_busy", 32'(busy), 32'd1);
    reset = 0;
    #1;
    check("abort_cmd",   32'(mem_cmd), 32'(MNONE));
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_acks",  32'({ack1, ack0}), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    req0 = 0; cmd0 = MNONE;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    run_txn(0, MREAD, 9'h007, 16'h0000);
    check("abort_ram_kept", 32'(rdata0), 32'h1111);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("no_pending_ack", 32'(ack_due), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 9, memory-bus address width.
REQ-002 Parameter DW, default 16, memory-bus data width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req0  in  1  port-0 (CPU) request, held until ack0.
REQ-006 cmd0  in  2  port-0 command (MNONE/MREAD/MWRITE).
REQ-007 addr0  in  AW  port-0 address; wdata0 in DW, port-0 write data.
REQ-008 ack0  out  1  one-cycle completion pulse for port 0; rdata0 out DW, port-0 read data.
REQ-009 req1, cmd1, addr1, wdata1, ack1, rdata1 SHALL mirror REQ-005..008 for port 1 (loader/debug master).
REQ-010 mem_cmd  out  2  shared-bus command to RAM and I/O decode.
REQ-011 mem_addr  out  AW; w_data out DW; r_data in DW, bus read data valid in the cycle after the MREAD cycle.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and RESP only.
REQ-014 A port SHALL be eligible when reqN=1 and cmdN is MREAD or MWRITE; MNONE or 2'b11 with reqN=1 is ignored and never acked.
REQ-015 IDLE with no eligible port: remain in IDLE.
REQ-016 IDLE with one eligible port: grant it, latch its cmd/addr/wdata into the bus registers, go to ACCESS.
REQ-017 IDLE with both eligible: grant the port not granted last (round-robin pointer); the pointer resets to port 1 so port 0 wins the first tie.
REQ-018 ACCESS: mem_cmd, mem_addr and w_data SHALL carry the granted transaction for exactly one cycle; next state RESP.
REQ-019 RESP: assert ackN of the granted port for exactly one cycle; on MREAD, load rdataN from r_data on that RESP edge; next state IDLE.
REQ-020 On MWRITE, rdataN SHALL be unchanged; rdataN otherwise holds its value until the next read for that port.
REQ-021 Latency: request sampled at IDLE edge k, bus active in cycle k+1, ack in cycle k+2; one transaction per 3 cycles maximum.
REQ-022 Outside ACCESS, mem_cmd SHALL be MNONE; mem_addr and w_data hold their last values.
REQ-023 The round-robin pointer SHALL update to the granted port on every grant.
REQ-024 Requester inputs changing while not granted SHALL have no effect on an in-flight transaction (latched values are used).
REQ-025 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-026 On reset low, immediately: state IDLE, mem_cmd MNONE, ack0=ack1=0, busy=0, without waiting for clk.
REQ-027 Reset values: mem_addr 0, w_data 0, rdata0 0, rdata1 0, pointer = port 1.
REQ-028 Reset asserted during ACCESS SHALL abort the transaction: no write reaches the bus and no ack is issued.
REQ-029 After reset release, the first eligible request SHALL be granted at the first rising edge.

Structure
REQ-030 Shared package mem_bus_pkg SHALL hold MNONE=2'b00, MWRITE=2'b01, MREAD=2'b10, the FSM state encoding, and the I/O addresses LED=9'h100, SW=9'h140.
REQ-031 One sub-module rr_pick2: combinational 2-way round-robin grant from eligibility bits and pointer.
REQ-032 Address decode and RAM/I/O tri-state control SHALL remain outside this block.

Verification
REQ-033 Port 0 MWRITE addr 9'h005 wdata 16'hBEEF -> mem_cmd=MWRITE, mem_addr=9'h005, w_data=16'hBEEF for one cycle; ack0 the next cycle; rdata0 unchanged.
REQ-034 Port 1 MREAD addr 9'h005, bus returns r_data=16'hBEEF -> rdata1=16'hBEEF and ack1 in cycle k+2; ack0 stays 0.
REQ-035 req0 and req1 both held for 4 transactions after reset -> grant order 0,1,0,1; the acks never overlap.
REQ-036 req0=1 with cmd0=MNONE for 10 cycles -> mem_cmd stays MNONE, busy=0, no ack0.
REQ-037 reset driven low mid-cycle while in ACCESS with MWRITE -> mem_cmd=MNONE before the next edge; no ack; the RAM location keeps its old value.
REQ-038 Port 0 MWRITE to 9'h100 with data 16'h00A5 -> bus shows MWRITE 9'h100 16'h00A5 and ack0 in cycle k+2.
